// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    // Bit positions inside the 3-bit operand-use code of the ID instruction.
    localparam int FWD_RS1 = 2;
    localparam int FWD_RS2 = 1;
    localparam int FWD_RD  = 0;

    localparam int REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the operands read in ID.
// Purely combinational, zero latency, no flow control.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [2:0]            id_fwd_risk,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_fwd_risk[FWD_RS1] && (id_rs1 == ex_rd);
        rs2_hit  = id_fwd_risk[FWD_RS2] && (id_rs2 == ex_rd);
        // x0 is never a real destination, so a load to it cannot create a hazard.
        load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller (RUN/MEM_WAIT/ERROR FSM); enables and flushes are combinational, 0-cycle.
// PIPELINE_CTRL_PERF_EN adds 32-bit stall_cnt/flush_cnt performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [2:0]            id_fwd_risk,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_redirect,
    input  logic                  dmem_req,
    input  logic                  dmem_ack,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic                  mem_timeout_err
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        load_use;
    logic        run_rules;
    logic        redirect_act;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_fwd_risk (id_fwd_risk),
        .load_use    (load_use)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        run_rules = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (dmem_req && !dmem_ack) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = '0;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // The ack cycle already behaves as RUN so the pipeline resumes without a bubble.
                if (dmem_ack) begin
                    state_d   = ST_RUN;
                    run_rules = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == TMO) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ERROR: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b1;
        redirect_act = 1'b0;
        if (!rst_n) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (run_rules) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
            mem_wb_flush = 1'b0;
            // Redirect wins: the stalled ID instruction is on the wrong path anyway.
            if (ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                redirect_act = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (state_q != ST_ERROR)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (redirect_act) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (TIMEOUT_CYC=4); perf checks when PIPELINE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic [2:0] id_fwd_risk;
    logic       ex_mem_read, ex_redirect, dmem_req, dmem_ack;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout_err;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [4:0] en;
    logic [2:0] fl;
    assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl = {if_id_flush, id_ex_flush, mem_wb_flush};

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_ADDR_W(5), .TIMEOUT_CYC(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_fwd_risk     (id_fwd_risk),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_redirect     (ex_redirect),
        .dmem_req        (dmem_req),
        .dmem_ack        (dmem_ack),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .mem_timeout_err (mem_timeout_err)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are checked 1 time unit later.
    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] risk, input logic redir,
                          input logic req, input logic ack);
        @(negedge clk);
        ex_mem_read = mr;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_fwd_risk = risk;
        ex_redirect = redir;
        dmem_req    = req;
        dmem_ack    = ack;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_fwd_risk = '0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
        #3;
        chk("rst_en", 32'(en), 32'b00000);
        chk("rst_fl", 32'(fl), 32'b111);
        chk("rst_err", 32'(mem_timeout_err), 32'd0);
`ifdef PIPELINE_CTRL_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0);
        chk("idle_en", 32'(en), 32'b11111);
        chk("idle_fl", 32'(fl), 32'b000);

        set_in(1, 5, 5, 0, 3'b101, 0, 0, 0);
        chk("lu_rs1_en", 32'(en), 32'b00111);
        chk("lu_rs1_fl", 32'(fl), 32'b010);

        set_in(1, 5, 0, 5, 3'b010, 0, 0, 0);
        chk("lu_rs2_en", 32'(en), 32'b00111);
        chk("lu_rs2_fl", 32'(fl), 32'b010);

        set_in(1, 5, 5, 5, 3'b001, 0, 0, 0);
        chk("lu_norisk_en", 32'(en), 32'b11111);

        set_in(1, 0, 0, 0, 3'b110, 0, 0, 0);
        chk("lu_x0_en", 32'(en), 32'b11111);
        chk("lu_x0_fl", 32'(fl), 32'b000);

        set_in(0, 5, 5, 0, 3'b101, 0, 0, 0);
        chk("noload_en", 32'(en), 32'b11111);

        set_in(1, 5, 5, 0, 3'b101, 1, 0, 0);
        chk("redir_lu_en", 32'(en), 32'b11111);
        chk("redir_lu_fl", 32'(fl), 32'b110);

        set_in(0, 0, 0, 0, 3'b000, 0, 1, 0);
        chk("miss_c0_en", 32'(en), 32'b00000);
        chk("miss_c0_fl", 32'(fl), 32'b001);
        set_in(0, 0, 0, 0, 3'b000, 0, 1, 0);
        chk("miss_c1_en", 32'(en), 32'b00000);
        chk("miss_c1_fl", 32'(fl), 32'b001);
        set_in(0, 0, 0, 0, 3'b000, 0, 1, 0);
        chk("miss_c2_en", 32'(en), 32'b00000);
        set_in(0, 0, 0, 0, 3'b000, 0, 1, 1);
        chk("miss_ack_en", 32'(en), 32'b11111);
        chk("miss_ack_fl", 32'(fl), 32'b000);

        set_in(0, 0, 0, 0, 3'b000, 0, 1, 1);
        chk("hit_en", 32'(en), 32'b11111);
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0);
        chk("after_hit_en", 32'(en), 32'b11111);
`ifdef PIPELINE_CTRL_PERF_EN
        chk("perf_stall_cnt", stall_cnt, 32'd5);
        chk("perf_flush_cnt", flush_cnt, 32'd1);
`endif

        // Timeout: one RUN miss cycle, then four MEM_WAIT cycles without ack.
        set_in(0, 0, 0, 0, 3'b000, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 3'b000, 0, 1, 0);
            chk("tmo_wait_err", 32'(mem_timeout_err), 32'd0);
        end
        set_in(0, 0, 0, 0, 3'b000, 0, 1, 0);
        chk("tmo_err", 32'(mem_timeout_err), 32'd1);
        chk("tmo_err_en", 32'(en), 32'b00000);
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 1);
        chk("err_sticky", 32'(mem_timeout_err), 32'd1);
        chk("err_ack_en", 32'(en), 32'b00000);

        // Asynchronous reset out of ERROR, between clock edges.
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_err_clr", 32'(mem_timeout_err), 32'd0);
        chk("arst_err_fl", 32'(fl), 32'b111);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0);
        chk("post_err_en", 32'(en), 32'b11111);
        chk("post_err_flag", 32'(mem_timeout_err), 32'd0);

        // Asynchronous reset mid-MEM_WAIT.
        set_in(0, 0, 0, 0, 3'b000, 0, 1, 0);
        set_in(0, 0, 0, 0, 3'b000, 0, 1, 0);
        chk("mw_en", 32'(en), 32'b00000);
        dmem_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_mw_en", 32'(en), 32'b00000);
        chk("arst_mw_fl", 32'(fl), 32'b111);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0);
        chk("post_mw_en", 32'(en), 32'b11111);
        chk("post_mw_fl", 32'(fl), 32'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
